pc_stack_array: RTL and testbench
=================================

// Module: pc_stack_array
// PURPOSE
//  Parametrised program-counter / return-address stack for the CPU core: DEPTH address
//  levels, one selected as the live PC by a stack pointer. Performs increment, jump,
//  in-page jump, call and return, and streams the PC out low-nibble-first on a nibble bus.
//  Replaces the fixed 4x12 array. Adds a command handshake, nibble-serial fetch and
//  optional overflow/underflow detection.
// PARAMETERS
//  ADDR_W  12  PC width in bits; multiple of 4, >= 8. NIB = ADDR_W/4 nibbles.
//  DEPTH   4   stack levels incl. live PC; power of 2, >= 2. SP_W = $clog2(DEPTH).
// PORTS
//  sysclk     in   1       single clock, all state on rising edge
//  poc_n      in   1       asynchronous active-low reset
//  cmd_valid  in   1       command request
//  cmd_ready  out  1       block can accept a command (high only in IDLE)
//  cmd_op     in   3       opcode (see BEHAVIOUR)
//  cmd_addr   in   ADDR_W  target address for JUMP/PJUMP/CALL
//  pc_out     out  ADDR_W  live PC = level[sp], registered
//  sp         out  SP_W    current stack pointer
//  nib_valid  out  1       nibble bus carries a PC nibble this cycle
//  nib_data   out  4       PC nibble, index nib_idx (0 = bits 3:0)
//  nib_last   out  1       final nibble of a fetch (nib_idx == NIB-1)
//  ovf        out  1       sticky call overflow (0 when macro absent)
//  unf        out  1       sticky return underflow (0 when macro absent)
// BEHAVIOUR
//  Reset (async assert, sync-deasserted upstream): all levels 0, sp 0, state IDLE,
//  cmd_ready 1, nib_valid/nib_last 0, nib_data 0, ovf/unf 0. Reset mid-FETCH aborts
//  the stream at once.
//  Accept = cmd_valid & cmd_ready. All single-cycle ops update state at the accept edge.
//  Results show on pc_out/sp the next cycle.
//  Opcodes: 0 NOP | 1 INC: pc <= pc+1, wraps 2^ADDR_W-1 -> 0 | 2 JUMP: pc <= cmd_addr
//   | 3 CALL: level[sp] <= pc+1 (return addr), sp <= sp+1, level[sp+1] <= cmd_addr
//   | 4 FETCH | 5 PJUMP: pc[7:0] <= cmd_addr[7:0], pc[ADDR_W-1:8] kept
//   | 6 CLRERR: ovf,unf <= 0 | 7 reserved, treated as NOP.
//  RET is opcode 7 only when RET_VIA_7 is false; RET is fixed as op 7 (behaviour:
//   sp <= sp-1; live PC becomes saved return level). Op 7 = RET; no reserved codes remain.
//  FETCH FSM: IDLE -> STREAM on accept at cycle T. The PC is captured at T.
//   Nibble k is driven at T+1+k, k = 0..NIB-1, with nib_valid=1. nib_last=1 at k=NIB-1.
//   On the nib_last edge: pc <= captured+1 (wrapping), state -> IDLE, cmd_ready=1 at T+NIB+1.
//   cmd_ready=0 throughout STREAM, so no other op can disturb the PC mid-stream.
//  Wrap without macro: sp is modulo DEPTH. CALL at sp=DEPTH-1 gives sp=0 and overwrites
//   level 0. RET at sp=0 gives sp=DEPTH-1. Silent.
//  Back-to-back commands are legal every cycle in IDLE. A held cmd_valid re-executes.
// CONFIGURATION
//  PC_STACK_ERR_DETECT_EN defined:
//   - CALL at sp=DEPTH-1 is rejected: no level/sp change, ovf <= 1.
//   - RET at sp=0 is rejected: unf <= 1.
//   - Flags stay set until CLRERR or reset.
//  Macro undefined: wrap as above; ovf/unf tied 0; CLRERR is a NOP.
// STRUCTURE
//  Package pc_stack_pkg:
//   - pcs_op_e (NOP,INC,JUMP,CALL,FETCH,PJUMP,CLRERR,RET)
//   - pcs_state_e (IDLE,STREAM)
//   - NIB_W=4 constant
//  Sub-module pc_incr: ADDR_W-bit +1 with carry-out (carry unused, wrap). Shared by INC,
//   CALL and FETCH completion.
//  Top holds the level array, sp, the FSM and the nibble index counter.
// TESTING
//  1 Reset, FETCH with pc=0x000 -> nibbles 0,0,0 at T+1..T+3, nib_last at T+3;
//    pc_out=0x001 at T+4; cmd_ready low T+1..T+3.
//  2 JUMP 0xFFF, INC -> pc_out=0x000. JUMP 0x3A5, PJUMP 0x0C7 -> pc_out=0x3C7.
//  3 JUMP 0x120, CALL 0x456 -> sp=1, pc_out=0x456. RET -> sp=0, pc_out=0x121.
//  4 DEPTH=4, 4 CALLs. No macro: sp=0, pc_out=4th target, ovf=0.
//    Macro: 4th CALL rejected, sp=3, ovf=1. CLRERR -> ovf=0.
//  5 RET at sp=0. No macro: sp=3. Macro: sp=0, unf=1, pc_out unchanged.
//  6 Assert poc_n low at 2nd nibble of a FETCH -> nib_valid=0 immediately; after release
//    pc_out=0, sp=0, cmd_ready=1.
//    Rerun 1-3 with ADDR_W=16, DEPTH=8 (4 nibbles per fetch).
```

Correction to the BEHAVIOUR block: ignore the "RET is opcode 7 only when RET_VIA_7 is false" line. There is no RET_VIA_7 parameter. Opcode 7 is always RET: sp <= sp-1, and the live PC becomes the saved return level. All eight codes are assigned, so no reserved codes remain.

Source files
------------

// File: rtl/pc_stack_pkg.sv
// Shared types and constants for the program-counter / return-address stack.
package pc_stack_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [2:0] {
    NOP    = 3'd0,
    INC    = 3'd1,
    JUMP   = 3'd2,
    CALL   = 3'd3,
    FETCH  = 3'd4,
    PJUMP  = 3'd5,
    CLRERR = 3'd6,
    RET    = 3'd7
  } pcs_op_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } pcs_state_e;

endpackage

// File: rtl/pc_incr.sv
// ADDR_W-bit +1. The carry is exposed but the stack wraps, so callers ignore it.
module pc_incr #(
  parameter int ADDR_W = 12
) (
  input  logic [ADDR_W-1:0] a,
  output logic [ADDR_W-1:0] sum,
  output logic              carry
);

  // single adder shared by INC, CALL return address and FETCH completion
  always_comb begin
    {carry, sum} = {1'b0, a} + {{ADDR_W{1'b0}}, 1'b1};
  end

endmodule

// File: rtl/pc_stack_array.sv
// PC / return-address stack with command handshake and nibble-serial fetch.
// Optional feature macro: PC_STACK_ERR_DETECT_EN (reject CALL at the top level
// and RET at the bottom level, flagging sticky ovf/unf).
module pc_stack_array
  import pc_stack_pkg::*;
#(
  parameter  int ADDR_W = 12,
  parameter  int DEPTH  = 4,
  localparam int SP_W   = $clog2(DEPTH)
) (
  input  logic              sysclk,
  input  logic              poc_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  output logic [ADDR_W-1:0] pc_out,
  output logic [SP_W-1:0]   sp,
  output logic              nib_valid,
  output logic [NIB_W-1:0]  nib_data,
  output logic              nib_last,
  output logic              ovf,
  output logic              unf
);

  localparam int NIB  = ADDR_W / NIB_W;
  localparam int NI_W = $clog2(NIB);
  localparam logic [NI_W-1:0] LAST_IDX = NI_W'(NIB - 1);

  logic [DEPTH-1:0][ADDR_W-1:0] lvl;
  logic [SP_W-1:0]   sp_q, sp_inc, sp_dec;
  pcs_state_e        state, state_nxt;
  logic [ADDR_W-1:0] cap, cap_sh, pc, inc_in, inc_out;
  logic [NI_W-1:0]   nib_idx;
  logic              inc_carry_unused;
  logic              accept, call_ok, ret_ok;
  pcs_op_e           op;

  assign pc        = lvl[sp_q];
  assign pc_out    = pc;
  assign sp        = sp_q;
  assign op        = pcs_op_e'(cmd_op);
  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign sp_inc    = sp_q + SP_W'(1);
  assign sp_dec    = sp_q - SP_W'(1);
  assign cap_sh    = cap >> (NIB_W * nib_idx);

  // while streaming the live PC is frozen, so the adder serves the captured value
  assign inc_in = (state == STREAM) ? cap : pc;

  pc_incr #(.ADDR_W(ADDR_W)) u_incr (
    .a     (inc_in),
    .sum   (inc_out),
    .carry (inc_carry_unused)
  );

`ifdef PC_STACK_ERR_DETECT_EN
  assign call_ok = (sp_q != SP_W'(DEPTH - 1));
  assign ret_ok  = (sp_q != '0);

  // sticky error flags, cleared only by CLRERR or reset
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (accept) begin
      if (op == CLRERR) begin
        ovf <= 1'b0;
        unf <= 1'b0;
      end else if (op == CALL && !call_ok) begin
        ovf <= 1'b1;
      end else if (op == RET && !ret_ok) begin
        unf <= 1'b1;
      end
    end
  end
`else
  assign call_ok = 1'b1;
  assign ret_ok  = 1'b1;
  assign ovf     = 1'b0;
  assign unf     = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // next state and nibble bus; outputs decode straight from registers so reset kills the stream at once
  always_comb begin
    state_nxt = state;
    nib_valid = 1'b0;
    nib_last  = 1'b0;
    nib_data  = '0;
    case (state)
      IDLE:   if (accept && op == FETCH) state_nxt = STREAM;
      STREAM: begin
        nib_valid = 1'b1;
        nib_data  = cap_sh[NIB_W-1:0];
        if (nib_idx == LAST_IDX) begin
          nib_last  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // level array, stack pointer, fetch capture and nibble index
  always_ff @(posedge sysclk or negedge poc_n) begin
    if (!poc_n) begin
      lvl     <= '0;
      sp_q    <= '0;
      cap     <= '0;
      nib_idx <= '0;
    end else if (state == STREAM) begin
      nib_idx <= nib_idx + NI_W'(1);
      if (nib_last) begin
        lvl[sp_q] <= inc_out;
        nib_idx   <= '0;
      end
    end else if (accept) begin
      case (op)
        INC:   lvl[sp_q] <= inc_out;
        JUMP:  lvl[sp_q] <= cmd_addr;
        CALL:  if (call_ok) begin
          lvl[sp_q]   <= inc_out;
          lvl[sp_inc] <= cmd_addr;
          sp_q        <= sp_inc;
        end
        FETCH: begin
          cap     <= pc;
          nib_idx <= '0;
        end
        PJUMP: lvl[sp_q][7:0] <= cmd_addr[7:0];
        RET:   if (ret_ok) sp_q <= sp_dec;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack_array.sv
// Directed bench: default build (12-bit, 4 levels) and a 16-bit, 8-level copy
// driven from the same command bus.
module tb_pc_stack_array;

  logic        sysclk = 1'b0;
  logic        poc_n  = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] addr = 16'h0;

  logic        rdy12, nv12, nl12, ovf12, unf12;
  logic [11:0] pc12;
  logic [1:0]  sp12;
  logic [3:0]  nd12;
  logic        rdy16, nv16, nl16, ovf16, unf16;
  logic [15:0] pc16;
  logic [2:0]  sp16;
  logic [3:0]  nd16;

  int n_vec = 0;
  int n_bad = 0;

  always #5 sysclk = ~sysclk;

  pc_stack_array #(.ADDR_W(12), .DEPTH(4)) u_dut12 (
    .sysclk(sysclk), .poc_n(poc_n), .cmd_valid(cmd_valid), .cmd_ready(rdy12),
    .cmd_op(cmd_op), .cmd_addr(addr[11:0]), .pc_out(pc12), .sp(sp12),
    .nib_valid(nv12), .nib_data(nd12), .nib_last(nl12), .ovf(ovf12), .unf(unf12)
  );

  pc_stack_array #(.ADDR_W(16), .DEPTH(8)) u_dut16 (
    .sysclk(sysclk), .poc_n(poc_n), .cmd_valid(cmd_valid), .cmd_ready(rdy16),
    .cmd_op(cmd_op), .cmd_addr(addr), .pc_out(pc16), .sp(sp16),
    .nib_valid(nv16), .nib_data(nd16), .nib_last(nl16), .ovf(ovf16), .unf(unf16)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] addr;
    logic [15:0] pc;   // 16-bit result; 12-bit DUT expects the low 12 bits
    logic [2:0]  sp;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 1'b0;
    poc_n = 1'b0;
    tick();
    tick();
    poc_n = 1'b1;
    tick();
  endtask

  task automatic cmd(input logic [2:0] op, input logic [15:0] a);
    cmd_op = op;
    addr = a;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  // FETCH of the current PC; checks nibble order, ready and completion on both DUTs
  task automatic do_fetch(input logic [15:0] pcv);
    logic [15:0] p12, p16;
    p12 = pcv & 16'h0FFF;
    p16 = pcv;
    cmd(3'd4, 16'h0);
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin
        chk("f12_valid", nv12, 1);
        chk("f12_data", nd12, (p12 >> (4 * k)) & 16'hF);
        chk("f12_last", nl12, k == 2);
        chk("f12_ready", rdy12, 0);
      end else begin
        chk("f12_valid_end", nv12, 0);
        chk("f12_ready_end", rdy12, 1);
        chk("f12_pc_end", pc12, (p12 + 16'd1) & 16'h0FFF);
      end
      if (k < 4) begin
        chk("f16_valid", nv16, 1);
        chk("f16_data", nd16, (p16 >> (4 * k)) & 16'hF);
        chk("f16_last", nl16, k == 3);
        chk("f16_ready", rdy16, 0);
      end else begin
        chk("f16_valid_end", nv16, 0);
        chk("f16_ready_end", rdy16, 1);
        chk("f16_pc_end", pc16, p16 + 16'd1);
      end
      tick();
    end
  endtask

  vec_t tbl[16];

  initial begin
    tbl[0]  = '{3'd2, 16'hFFFF, 16'hFFFF, 3'd0};  // JUMP all-ones
    tbl[1]  = '{3'd1, 16'h0000, 16'h0000, 3'd0};  // INC wraps
    tbl[2]  = '{3'd2, 16'h03A5, 16'h03A5, 3'd0};
    tbl[3]  = '{3'd5, 16'h00C7, 16'h03C7, 3'd0};  // PJUMP keeps upper bits
    tbl[4]  = '{3'd1, 16'h0000, 16'h03C8, 3'd0};
    tbl[5]  = '{3'd2, 16'h0120, 16'h0120, 3'd0};
    tbl[6]  = '{3'd3, 16'h0456, 16'h0456, 3'd1};  // CALL
    tbl[7]  = '{3'd3, 16'h0FF0, 16'h0FF0, 3'd2};  // nested CALL
    tbl[8]  = '{3'd7, 16'h0000, 16'h0457, 3'd1};  // RET to inner return addr
    tbl[9]  = '{3'd7, 16'h0000, 16'h0121, 3'd0};
    tbl[10] = '{3'd0, 16'hABCD, 16'h0121, 3'd0};  // NOP
    tbl[11] = '{3'd6, 16'h0000, 16'h0121, 3'd0};  // CLRERR leaves PC
    tbl[12] = '{3'd2, 16'h12FF, 16'h12FF, 3'd0};
    tbl[13] = '{3'd5, 16'h0034, 16'h1234, 3'd0};
    tbl[14] = '{3'd2, 16'h0FFF, 16'h0FFF, 3'd0};
    tbl[15] = '{3'd1, 16'h0000, 16'h1000, 3'd0};  // 12-bit wraps, 16-bit carries

    do_reset();
    chk("rst_pc12", pc12, 0);
    chk("rst_sp12", sp12, 0);
    chk("rst_ready12", rdy12, 1);
    chk("rst_nv12", nv12, 0);
    chk("rst_nl12", nl12, 0);
    chk("rst_nd12", nd12, 0);
    chk("rst_ovf12", ovf12, 0);
    chk("rst_unf12", unf12, 0);
    chk("rst_pc16", pc16, 0);
    chk("rst_sp16", sp16, 0);

    do_fetch(16'h0000);

    // back-to-back table: valid stays high across rows
    for (int i = 0; i < 16; i++) begin
      cmd_op = tbl[i].op;
      addr = tbl[i].addr;
      cmd_valid = 1'b1;
      tick();
      chk($sformatf("v%0d_pc12", i), pc12, tbl[i].pc & 16'h0FFF);
      chk($sformatf("v%0d_sp12", i), sp12, tbl[i].sp & 3'd3);
      chk($sformatf("v%0d_pc16", i), pc16, tbl[i].pc);
      chk($sformatf("v%0d_sp16", i), sp16, tbl[i].sp);
    end
    cmd_valid = 1'b0;

    // held valid re-executes: two INCs
    cmd_op = 3'd1;
    cmd_valid = 1'b1;
    tick();
    tick();
    cmd_valid = 1'b0;
    chk("held_inc12", pc12, 12'h002);
    chk("held_inc16", pc16, 16'h1002);

    // nonzero fetch pattern
    cmd(3'd2, 16'h93C7);
    do_fetch(16'h93C7);

    // overflow on 4 nested calls (12-bit, 4 levels)
    do_reset();
    cmd(3'd3, 16'h0100);
    cmd(3'd3, 16'h0200);
    cmd(3'd3, 16'h0300);
    cmd(3'd3, 16'h0400);
`ifdef PC_STACK_ERR_DETECT_EN
    chk("ovf_sp", sp12, 3);
    chk("ovf_pc", pc12, 12'h300);
    chk("ovf_flag", ovf12, 1);
    cmd(3'd6, 16'h0);
    chk("clrerr_ovf", ovf12, 0);
`else
    chk("wrap_sp", sp12, 0);
    chk("wrap_pc", pc12, 12'h400);
    chk("wrap_ovf", ovf12, 0);
    cmd(3'd7, 16'h0);
    chk("wrap_ret_sp", sp12, 3);
    chk("wrap_ret_pc", pc12, 12'h301);
`endif

    // underflow: RET at sp 0
    do_reset();
    cmd(3'd2, 16'h0055);
    cmd(3'd7, 16'h0);
`ifdef PC_STACK_ERR_DETECT_EN
    chk("unf_sp", sp12, 0);
    chk("unf_pc", pc12, 12'h055);
    chk("unf_flag", unf12, 1);
`else
    chk("unf_sp", sp12, 3);
    chk("unf_pc", pc12, 12'h000);
    chk("unf_flag", unf12, 0);
`endif

    // reset during the second nibble aborts the stream immediately
    do_reset();
    cmd(3'd2, 16'h03C7);
    cmd(3'd4, 16'h0);
    tick();
    chk("abort_pre_nv", nv12, 1);
    chk("abort_pre_nd", nd12, 4'hC);
    poc_n = 1'b0;
    #1;
    chk("abort_nv12", nv12, 0);
    chk("abort_nl12", nl12, 0);
    chk("abort_nv16", nv16, 0);
    tick();
    poc_n = 1'b1;
    tick();
    chk("abort_pc12", pc12, 0);
    chk("abort_sp12", sp12, 0);
    chk("abort_ready12", rdy12, 1);
    chk("abort_ready16", rdy16, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
